// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: enable generator for the PE clock-gating cell (latch + AND ICG).
// It drops clk_en after IDLE_CYCLES consecutive idle cycles. It restores clk_en
// when work or a force_on override arrives. It raises ready WAKE_CYCLES edges
// after clk_en returns. It runs in the ungated clk domain.
// Optional feature macro: CLK_GATE_STATS_EN adds stats_clr / gated_cycles.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy,
    input  logic             req_valid,
    input  logic             force_on,
`ifdef CLK_GATE_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] gated_cycles,
`endif
    output logic             clk_en,
    output logic             ready,
    output logic [1:0]       state
);

    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_GATED   = 2'b01,
        ST_WAKE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              clk_en_q, clk_en_d;
    logic              ready_q, ready_d;
    logic              idle;

    assign idle = !busy && !req_valid && !force_on;

    // Next-state logic. The enable and ready values are decoded from the next state,
    // so the outputs come straight from flops.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (idle) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_GATED;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_GATED: begin
                // The gated domain is frozen, so busy is stale here. Only new work or
                // the override wakes the domain.
                idle_cnt_d = '0;
                wake_cnt_d = '0;
                if (req_valid || force_on) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
        clk_en_d = (state_d != ST_GATED);
        ready_d  = (state_d == ST_RUN);
    end

    // State and counter registers. Reset leaves the clock running so that the
    // gated logic also sees its reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
            ready_q    <= ready_d;
        end
    end

    assign clk_en = clk_en_q;
    assign ready  = ready_q;
    assign state  = state_q;

`ifdef CLK_GATE_STATS_EN
    logic [CNT_W-1:0] gated_cycles_q;

    // Gated-cycle statistics. The clear has priority, and the count saturates
    // instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cycles_q <= '0;
        end else if (stats_clr) begin
            gated_cycles_q <= '0;
        end else if ((state_q == ST_GATED) && (gated_cycles_q != {CNT_W{1'b1}})) begin
            gated_cycles_q <= gated_cycles_q + 1'b1;
        end
    end

    assign gated_cycles = gated_cycles_q;
`endif

endmodule
